// File: rtl/sink_pop_scheduler_pkg.sv
// Shared width helper for the sink pop scheduler and its round-robin picker.
package sink_pop_scheduler_pkg;

   // Ceiling log2, clamped to 1 so it can size a vector even for a value of 1.
   function automatic int clogb(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/sink_rr_pick.sv
// Rotating-priority one-hot selector: grants the first set request at or above ptr, wrapping.
module sink_rr_pick
   import sink_pop_scheduler_pkg::*;
#(
   parameter int num_vcs = 8,
   parameter int ptr_w   = clogb(num_vcs)
) (
   input  logic [num_vcs-1:0] req,
   input  logic [ptr_w-1:0]   ptr,
   output logic [num_vcs-1:0] gnt
);

   logic             found;
   logic [ptr_w-1:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < num_vcs; i++) begin
         idx = ptr_w'((int'(ptr) + i) % num_vcs);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sink_pop_scheduler.sv
// Ejection-port pop scheduler: round-robin VC pick, optional head-to-tail lock,
// token-bucket throttle and a sticky watchdog on stalled locks.
module sink_pop_scheduler
   import sink_pop_scheduler_pkg::*;
#(
   parameter int num_vcs       = 8,
   parameter int refill_period = 1,
   parameter int burst_max     = 4,
   parameter int atomic_drain  = 1,
   parameter int stall_limit   = 64,
   localparam int tok_w        = clogb(burst_max + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [num_vcs-1:0] req_ivc,
   input  logic [num_vcs-1:0] tail_ivc,
   output logic               pop_valid,
   output logic [num_vcs-1:0] pop_sel_ivc,
   output logic               fc_event_valid,
   output logic [num_vcs-1:0] fc_event_sel_ivc,
   output logic [tok_w-1:0]   tokens,
   output logic               error
);

   localparam int vc_w    = clogb(num_vcs);
   localparam int ref_w   = clogb(refill_period);
   localparam int stall_w = clogb(stall_limit + 1);

   localparam logic [tok_w-1:0]   tok_max    = tok_w'(burst_max);
   localparam logic [ref_w-1:0]   ref_last   = ref_w'(refill_period - 1);
   localparam logic [stall_w-1:0] stall_max  = stall_w'(stall_limit);
   localparam logic [stall_w-1:0] stall_last = stall_w'(stall_limit - 1);
   localparam logic [vc_w-1:0]    last_vc    = vc_w'(num_vcs - 1);

   logic [vc_w-1:0]    rr_ptr;
   logic [vc_w-1:0]    lock_vc;
   logic               locked;
   logic [ref_w-1:0]   refill_cnt;
   logic [stall_w-1:0] stall_cnt;

   logic [num_vcs-1:0] rr_gnt;
   logic [num_vcs-1:0] cand;
   logic [vc_w-1:0]    gnt_idx;
   logic [vc_w-1:0]    nxt_ptr;
   logic               pop_tail;
   logic               refill;
   logic               stalling;
   logic [tok_w-1:0]   tokens_next;

   // Bucket level after one cycle; a refill into a full bucket is lost.
   function automatic logic [tok_w-1:0] sat_tokens(input logic [tok_w-1:0] lvl,
                                                   input logic add,
                                                   input logic sub);
      int sum;
      sum = int'(lvl) + int'(add) - int'(sub);
      if (sum > burst_max) sum = burst_max;
      if (sum < 0) sum = 0;
      return tok_w'(sum);
   endfunction

   sink_rr_pick #(
      .num_vcs (num_vcs),
      .ptr_w   (vc_w)
   ) u_rr_pick (
      .req (req_ivc),
      .ptr (rr_ptr),
      .gnt (rr_gnt)
   );

   // While locked only the locked VC may win, even if others are requesting.
   always_comb begin
      cand = rr_gnt;
      if (locked) begin
         cand          = '0;
         cand[lock_vc] = req_ivc[lock_vc];
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < num_vcs; i++) begin
         if (cand[i]) gnt_idx = vc_w'(i);
      end
   end

   assign nxt_ptr          = (gnt_idx == last_vc) ? '0 : gnt_idx + vc_w'(1);
   assign pop_valid        = ~reset & enable & (tokens != '0) & (|cand);
   assign pop_sel_ivc      = pop_valid ? cand : '0;
   assign fc_event_valid   = pop_valid;
   assign fc_event_sel_ivc = pop_sel_ivc;
   assign pop_tail         = |(cand & tail_ivc);
   assign refill           = (refill_cnt == ref_last);
   assign stalling         = locked & ~req_ivc[lock_vc] & enable;
   assign tokens_next      = sat_tokens(tokens, refill, pop_valid);

   always_ff @(posedge clk) begin
      if (reset) begin
         tokens     <= tok_max;
         refill_cnt <= '0;
         rr_ptr     <= '0;
         locked     <= 1'b0;
         stall_cnt  <= '0;
         error      <= 1'b0;
      end else begin
         tokens     <= tokens_next;
         refill_cnt <= refill ? '0 : refill_cnt + ref_w'(1);

         if (pop_valid) begin
            if (pop_tail || atomic_drain == 0) begin
               locked <= 1'b0;
               rr_ptr <= nxt_ptr;
            end else begin
               locked <= 1'b1;
            end
         end

         if (pop_valid || !locked) begin
            stall_cnt <= '0;
         end else if (stalling && stall_cnt != stall_max) begin
            stall_cnt <= stall_cnt + stall_w'(1);
         end

         // Raised on the edge where the count reaches the limit; lock is kept.
         if (stalling && stall_cnt >= stall_last) error <= 1'b1;
      end
   end

   // lock_vc is only meaningful while locked, so it carries no reset.
   always_ff @(posedge clk) begin
      if (pop_valid && !pop_tail && atomic_drain != 0) lock_vc <= gnt_idx;
   end

endmodule

// File: tb/tb_sink_pop_scheduler.sv
// Scoreboard bench: two scheduler instances (full rate, and throttled 4-cycle/2-deep bucket).
module tb_sink_pop_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, enable_a;
   logic [7:0] req_a, tail_a;
   logic       pop_valid_a, fc_valid_a, error_a;
   logic [7:0] pop_sel_a, fc_sel_a;
   logic [2:0] tokens_a;

   logic       rst_b, enable_b;
   logic [7:0] req_b, tail_b;
   logic       pop_valid_b, fc_valid_b, error_b;
   logic [7:0] pop_sel_b, fc_sel_b;
   logic [1:0] tokens_b;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic [7:0] e_a, e_b;

   sink_pop_scheduler #(
      .num_vcs(8), .refill_period(1), .burst_max(4), .atomic_drain(1), .stall_limit(64)
   ) dut_a (
      .clk(clk), .reset(reset), .enable(enable_a), .req_ivc(req_a), .tail_ivc(tail_a),
      .pop_valid(pop_valid_a), .pop_sel_ivc(pop_sel_a), .fc_event_valid(fc_valid_a),
      .fc_event_sel_ivc(fc_sel_a), .tokens(tokens_a), .error(error_a)
   );

   sink_pop_scheduler #(
      .num_vcs(8), .refill_period(4), .burst_max(2), .atomic_drain(1), .stall_limit(64)
   ) dut_b (
      .clk(clk), .reset(rst_b), .enable(enable_b), .req_ivc(req_b), .tail_ivc(tail_b),
      .pop_valid(pop_valid_b), .pop_sel_ivc(pop_sel_b), .fc_event_valid(fc_valid_b),
      .fc_event_sel_ivc(fc_sel_b), .tokens(tokens_b), .error(error_b)
   );

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (pop_valid_a) begin
         if (exp_a.size() == 0) begin
            chk("a_unexpected_pop", int'(pop_sel_a), 0);
         end else begin
            e_a = exp_a.pop_front();
            chk("a_pop_sel", int'(pop_sel_a), int'(e_a));
            chk("a_fc_sel", int'(fc_sel_a), int'(e_a));
            chk("a_fc_valid", int'(fc_valid_a), 1);
         end
      end else begin
         chk("a_idle_outputs", int'({fc_valid_a, pop_sel_a, fc_sel_a}), 0);
      end
   end

   always @(negedge clk) begin
      if (pop_valid_b) begin
         if (exp_b.size() == 0) begin
            chk("b_unexpected_pop", int'(pop_sel_b), 0);
         end else begin
            e_b = exp_b.pop_front();
            chk("b_pop_sel", int'(pop_sel_b), int'(e_b));
            chk("b_fc_sel", int'(fc_sel_b), int'(e_b));
            chk("b_fc_valid", int'(fc_valid_b), 1);
         end
      end else begin
         chk("b_idle_outputs", int'({fc_valid_b, pop_sel_b, fc_sel_b}), 0);
      end
   end

   task automatic step_a(input logic rst, input logic [7:0] req, input logic [7:0] tail,
                         input logic en, input logic [7:0] exp);
      @(posedge clk); #1;
      reset    = rst;
      req_a    = req;
      tail_a   = tail;
      enable_a = en;
      if (exp != 8'h00) exp_a.push_back(exp);
      @(negedge clk); #1;
      chk("a_pending_pop", exp_a.size(), 0);
      exp_a.delete();
   endtask

   task automatic step_b(input logic rst, input logic [7:0] req, input logic [7:0] tail,
                         input logic en, input logic [7:0] exp);
      @(posedge clk); #1;
      rst_b    = rst;
      req_b    = req;
      tail_b   = tail;
      enable_b = en;
      if (exp != 8'h00) exp_b.push_back(exp);
      @(negedge clk); #1;
      chk("b_pending_pop", exp_b.size(), 0);
      exp_b.delete();
   endtask

   initial begin
      logic       en;
      logic [7:0] ex;
      reset = 1'b1; req_a = '0; tail_a = '0; enable_a = 1'b0;
      rst_b = 1'b1; req_b = '0; tail_b = '0; enable_b = 1'b0;

      // Reset: outputs forced low even with requests present.
      step_a(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00);
      chk("a_reset_pop_valid", int'(pop_valid_a), 0);
      step_a(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00);
      chk("a_reset_tokens", int'(tokens_a), 4);
      chk("a_reset_error", int'(error_a), 0);

      // Full-rate round robin on VC2/VC5, single-flit packets.
      step_a(1'b0, 8'b0010_0100, 8'hFF, 1'b1, 8'h04);
      step_a(1'b0, 8'b0010_0100, 8'hFF, 1'b1, 8'h20);
      step_a(1'b0, 8'b0010_0100, 8'hFF, 1'b1, 8'h04);
      chk("a_tokens_full_rate", int'(tokens_a), 4);
      step_a(1'b0, 8'h00, 8'hFF, 1'b1, 8'h00);

      // Atomic drain of VC3 (ptr=3) while VC1 waits; then ptr must be 4.
      step_a(1'b0, 8'b0000_1010, 8'h00, 1'b1, 8'h08);
      step_a(1'b0, 8'b0000_1010, 8'h00, 1'b1, 8'h08);
      step_a(1'b0, 8'b0000_1010, 8'h08, 1'b1, 8'h08);
      step_a(1'b0, 8'b0001_1010, 8'hFF, 1'b1, 8'h10);
      step_a(1'b0, 8'b0000_1010, 8'hFF, 1'b1, 8'h02);
      step_a(1'b0, 8'h00, 8'h00, 1'b1, 8'h00);

      // Watchdog: lock VC6, only VC1 requests; 3 disabled cycles must not count.
      step_a(1'b1, 8'h00, 8'h00, 1'b0, 8'h00);
      step_a(1'b0, 8'h40, 8'h00, 1'b1, 8'h40);
      for (int i = 0; i < 66; i++) begin
         en = !(i >= 10 && i < 13);
         step_a(1'b0, 8'h02, 8'hFF, en, 8'h00);
      end
      step_a(1'b0, 8'h02, 8'hFF, 1'b1, 8'h00);
      chk("a_error_before_limit", int'(error_a), 0);
      step_a(1'b0, 8'h40, 8'h40, 1'b1, 8'h40);
      chk("a_error_at_limit", int'(error_a), 1);
      step_a(1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
      chk("a_error_sticky", int'(error_a), 1);
      step_a(1'b1, 8'h00, 8'h00, 1'b1, 8'h00);
      step_a(1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
      chk("a_error_cleared", int'(error_a), 0);

      // Reset mid-packet on VC3 drops the lock; next grant is VC1 from ptr 0.
      step_a(1'b0, 8'h08, 8'h00, 1'b1, 8'h08);
      step_a(1'b1, 8'b0000_1010, 8'h00, 1'b1, 8'h00);
      chk("a_reset_mid_packet", int'(pop_valid_a), 0);
      step_a(1'b0, 8'b0000_1010, 8'h00, 1'b1, 8'h02);
      step_a(1'b0, 8'h00, 8'h00, 1'b1, 8'h00);

      // Throttled instance: 2 back-to-back pops then one per 4 cycles.
      step_b(1'b1, 8'h00, 8'hFF, 1'b1, 8'h00);
      for (int c = 0; c < 14; c++) begin
         ex = (c == 0 || c == 1 || c == 4 || c == 8 || c == 12) ? 8'h01 : 8'h00;
         step_b(1'b0, 8'h01, 8'hFF, 1'b1, ex);
         if (c == 0) chk("b_tokens_initial", int'(tokens_b), 2);
         checks++;
         if (tokens_b > 2'd2) begin
            errors++;
            $display("FAIL b_tokens_bound actual=%0d required<=2", tokens_b);
         end
      end
      for (int c = 14; c < 24; c++) begin
         step_b(1'b0, 8'h01, 8'hFF, 1'b0, 8'h00);
      end
      for (int c = 24; c < 29; c++) begin
         ex = (c == 24 || c == 25 || c == 28) ? 8'h01 : 8'h00;
         step_b(1'b0, 8'h01, 8'hFF, 1'b1, ex);
         if (c == 24) chk("b_tokens_after_idle", int'(tokens_b), 2);
      end
      step_b(1'b0, 8'h00, 8'hFF, 1'b1, 8'h00);
      chk("b_error_clear", int'(error_b), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sink_pop_scheduler.md
# sink_pop_scheduler

Pop scheduler for the per-VC flit buffer at a network sink (terminal ejection port). Each cycle it picks at most one non-empty input VC to drain, chosen round-robin and throttled by a token-bucket rate limiter. It optionally locks onto one VC from head to tail so packets drain atomically. It drives the buffer's pop handshake and the same-cycle credit event into the flow-control output stage, and flags a sticky error when a locked VC stalls too long.

## Interface
- num_vcs, 8, number of input VCs (≥2)
- refill_period, 1, cycles per token refill (1 = full rate)
- burst_max, 4, token bucket depth (≥1)
- atomic_drain, 1, 1 = hold VC from granted flit through its tail; 0 = re-arbitrate every pop
- stall_limit, 64, cycles a locked VC may sit with no request before error
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  downstream sink ready; 0 suppresses all pops
- req_ivc  in  num_vcs  VC has a poppable flit (buffered or bypassing)
- tail_ivc  in  num_vcs  flit currently at head of VC is a tail
- pop_valid  out  1  pop one flit this cycle
- pop_sel_ivc  out  num_vcs  one-hot VC to pop; all-zero when pop_valid=0
- fc_event_valid  out  1  credit return, equals pop_valid
- fc_event_sel_ivc  out  num_vcs  equals pop_sel_ivc
- tokens  out  clogb(burst_max+1)  current bucket level (debug)
- error  out  1  sticky lock-stall error

## Operation
- Eligibility: pop allowed when enable & (tokens>0) & candidate request present.
- Unlocked: candidate = first set bit of req_ivc at or after rr_ptr, scanning upward with wrap.
- Locked (atomic_drain=1): candidate = lock_vc only, if req_ivc[lock_vc]; other VCs are ignored even when requesting.
- On a pop of a non-tail flit with atomic_drain=1: lock_vc ← granted VC, locked ← 1.
- On a pop of a tail flit: locked ← 0; rr_ptr ← (granted+1) mod num_vcs.
- atomic_drain=0: rr_ptr ← granted+1 after every pop; never locked.
- Single-flit packet (tail on first pop): never locks; pointer advances.
- Token bucket: refill_cnt counts 0..refill_period-1 and wraps; refill pulse on wrap. tokens_next = min(burst_max, tokens + refill − pop). Refill and pop in the same cycle at tokens=burst_max leaves the bucket at burst_max. Refill while tokens=burst_max and no pop is discarded.
- Watchdog: stall_cnt increments while locked & ~req_ivc[lock_vc] & enable; clears on any pop or unlock. At stall_cnt==stall_limit, error ← 1 (sticky until reset). Lock is retained.
- enable=0: no pop; tokens still refill; stall_cnt holds.

## Timing
- pop_valid/pop_sel_ivc/fc_event_* are combinational from the current req_ivc, tail_ivc, enable and registered state. Zero-cycle latency from request to pop, matching the buffer's edge-triggered pop.
- All state updates on posedge clk.
- Reset (sync): tokens=burst_max, refill_cnt=0, rr_ptr=0, locked=0, stall_cnt=0, error=0. Combinational pop outputs are forced 0 while reset=1.
- Reset mid-packet drops the lock; the next grant is round-robin from VC0.
- Throughput: sustained one pop per refill_period cycles; up to burst_max back-to-back pops after idle.

## Structure
- Width helpers (clogb) come from c_functions.v. No new typedefs; no additions to rtr_constants.v.
- One sub-module: sink_rr_pick, a combinational rotating-priority one-hot selector (req, ptr → gnt).
- Remaining logic (lock register, token/refill counters, watchdog) stays in the top module.

## Test plan
- After reset, req_ivc=8'b00100100, all tail, refill_period=1 → pops VC2 then VC5 then VC2 on consecutive cycles; fc_event mirrors each pop.
- atomic_drain=1: VC3 presents head, body, tail while VC1 requests throughout → three consecutive pops on VC3, then VC1; rr_ptr=4 after the tail.
- refill_period=4, burst_max=2, continuous requests → 2 back-to-back pops, then one pop every 4 cycles; tokens never exceed 2.
- enable=0 for 10 cycles with requests pending → no pops, tokens saturate at burst_max; enable=1 → burst_max immediate pops.
- Lock VC6, drop req_ivc[6] for stall_limit=64 cycles → error rises on cycle 64 and stays high after the request returns; reset clears it.
- Reset asserted mid-packet on VC3 → outputs 0 that cycle; after release the next grant goes to the lowest requesting VC from 0.
